// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: instruction type codes, opcodes and the
// decoded-entry record stored in the decode queue.
package decode_queue_pkg;

  localparam int TYPE_BIT = 6;

  typedef enum logic [TYPE_BIT-1:0] {
    TYPE_ILLEGAL = 6'd0,
    TYPE_LUI, TYPE_AUIPC, TYPE_JAL, TYPE_JALR,
    TYPE_BEQ, TYPE_BNE, TYPE_BLT, TYPE_BGE, TYPE_BLTU, TYPE_BGEU,
    TYPE_LB, TYPE_LH, TYPE_LW, TYPE_LBU, TYPE_LHU,
    TYPE_SB, TYPE_SH, TYPE_SW,
    TYPE_ADDI, TYPE_SLTI, TYPE_SLTIU, TYPE_XORI, TYPE_ORI, TYPE_ANDI,
    TYPE_SLLI, TYPE_SRLI, TYPE_SRAI,
    TYPE_ADD, TYPE_SUB, TYPE_SLL, TYPE_SLT, TYPE_SLTU, TYPE_XOR,
    TYPE_SRL, TYPE_SRA, TYPE_OR, TYPE_AND
  } inst_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    inst_type_e  op_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  typedef struct packed {
    decoded_t    dec;
    logic [31:0] pc;
  } queue_entry_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder: raw word -> type, register fields,
// immediate and illegal flag. Illegal words report type 0, rd 0 and imm 0.
module rv32i_decode_comb
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  inst_type_e  op;
  logic [4:0]  rd_sel;
  logic [31:0] imm_sel;
  logic        illegal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op      = TYPE_ILLEGAL;
    rd_sel  = inst[11:7];
    imm_sel = '0;
    case (opcode)
      OPC_LUI:   begin op = TYPE_LUI;   imm_sel = imm_u; end
      OPC_AUIPC: begin op = TYPE_AUIPC; imm_sel = imm_u; end
      OPC_JAL:   begin op = TYPE_JAL;   imm_sel = imm_j; end
      OPC_JALR:  begin
        imm_sel = imm_i;
        if (funct3 == 3'b000) op = TYPE_JALR;
      end
      OPC_BRANCH: begin
        imm_sel = imm_b;
        rd_sel  = '0;
        case (funct3)
          3'b000:  op = TYPE_BEQ;
          3'b001:  op = TYPE_BNE;
          3'b100:  op = TYPE_BLT;
          3'b101:  op = TYPE_BGE;
          3'b110:  op = TYPE_BLTU;
          3'b111:  op = TYPE_BGEU;
          default: op = TYPE_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        imm_sel = imm_i;
        case (funct3)
          3'b000:  op = TYPE_LB;
          3'b001:  op = TYPE_LH;
          3'b010:  op = TYPE_LW;
          3'b100:  op = TYPE_LBU;
          3'b101:  op = TYPE_LHU;
          default: op = TYPE_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        imm_sel = imm_s;
        rd_sel  = '0;
        case (funct3)
          3'b000:  op = TYPE_SB;
          3'b001:  op = TYPE_SH;
          3'b010:  op = TYPE_SW;
          default: op = TYPE_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        imm_sel = imm_i;
        case (funct3)
          3'b000: op = TYPE_ADDI;
          3'b010: op = TYPE_SLTI;
          3'b011: op = TYPE_SLTIU;
          3'b100: op = TYPE_XORI;
          3'b110: op = TYPE_ORI;
          3'b111: op = TYPE_ANDI;
          3'b001: begin
            imm_sel = imm_sh;
            if (funct7 == 7'b0000000) op = TYPE_SLLI;
          end
          default: begin
            imm_sel = imm_sh;
            if (funct7 == 7'b0000000)      op = TYPE_SRLI;
            else if (funct7 == 7'b0100000) op = TYPE_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          10'b0000000_000: op = TYPE_ADD;
          10'b0100000_000: op = TYPE_SUB;
          10'b0000000_001: op = TYPE_SLL;
          10'b0000000_010: op = TYPE_SLT;
          10'b0000000_011: op = TYPE_SLTU;
          10'b0000000_100: op = TYPE_XOR;
          10'b0000000_101: op = TYPE_SRL;
          10'b0100000_101: op = TYPE_SRA;
          10'b0000000_110: op = TYPE_OR;
          10'b0000000_111: op = TYPE_AND;
          default:         op = TYPE_ILLEGAL;
        endcase
      end
      default: op = TYPE_ILLEGAL;
    endcase
  end

  assign illegal     = (op == TYPE_ILLEGAL);
  assign dec.op_type = op;
  assign dec.rs1     = inst[19:15];
  assign dec.rs2     = inst[24:20];
  assign dec.rd      = illegal ? 5'd0 : rd_sel;
  assign dec.imm     = illegal ? 32'd0 : imm_sel;
  assign dec.illegal = illegal;

endmodule

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: decodes fetched words on entry and holds them in
// a DEPTH-entry FIFO with valid/ready on both sides, flush and global pause.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [31:0]         in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TYPE_BIT-1:0] out_type,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [31:0]         out_imm,
  output logic [31:0]         out_pc,
  output logic                out_illegal,
  output logic [PTR_W:0]      count_out
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

  decoded_t         in_dec;
  queue_entry_t     mem [DEPTH];
  queue_entry_t     head_entry;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             push, pop;

  rv32i_decode_comb u_decode (
    .inst (in_inst),
    .dec  (in_dec)
  );

  // Full blocks a push even when a pop happens in the same cycle (no write-through).
  assign in_ready  = rdy_in && !flush_in && (count != FULL_CNT);
  assign out_valid = rdy_in && !flush_in && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + ONE_CNT;
        else if (pop && !push) count <= count - ONE_CNT;
      end
    end
  end

  // NOTE: storage is deliberately not reset; head data is meaningless while out_valid is low.
  always_ff @(posedge clk_in) begin
    if (push) mem[tail] <= '{dec: in_dec, pc: in_pc};
  end

  assign head_entry  = mem[head];
  assign out_type    = head_entry.dec.op_type;
  assign out_rs1     = head_entry.dec.rs1;
  assign out_rs2     = head_entry.dec.rs2;
  assign out_rd      = head_entry.dec.rd;
  assign out_imm     = head_entry.dec.imm;
  assign out_pc      = head_entry.pc;
  assign out_illegal = head_entry.dec.illegal;
  assign count_out   = count;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vectors, fill/drain ordering,
// full and simultaneous push/pop, pause, flush and asynchronous reset.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic                clk_in = 1'b0;
  logic                rst_in, rdy_in, flush_in, in_valid, out_ready;
  logic                in_ready, out_valid, out_illegal;
  logic [31:0]         in_inst, in_pc, out_imm, out_pc;
  logic [TYPE_BIT-1:0] out_type;
  logic [4:0]          out_rs1, out_rs2, out_rd;
  logic [PTR_W:0]      count_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] W_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] W_BEQ  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] W_SRAI = 32'h4020_D093;  // srai x1,x1,2
  localparam logic [31:0] W_ILL  = 32'hFFFF_FFFF;
  localparam logic [31:0] W_ADD2 = 32'h0010_0113;  // addi x2,x0,1

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .count_out   (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] pc);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    step();
    step();
    rst_in = 1'b0;
    #1;
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5 visible in the cycle after acceptance
    push(W_ADDI, 32'h0);
    #1;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_type", 32'(out_type), 32'(TYPE_ADDI));
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_illegal", 32'(out_illegal), 32'd0);
    check("addi_count", 32'(count_out), 32'd1);
    pop_expect("addi_pop", 32'h0);
    check("empty_after_pop", 32'(count_out), 32'd0);

    // back-to-back pushes of branch and shift
    push(W_BEQ, 32'h4);
    push(W_SRAI, 32'h8);
    #1;
    check("beq_type", 32'(out_type), 32'(TYPE_BEQ));
    check("beq_rd", 32'(out_rd), 32'd0);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    pop_expect("beq_pop", 32'h4);
    check("srai_type", 32'(out_type), 32'(TYPE_SRAI));
    check("srai_imm", out_imm, 32'd2);
    check("srai_rd", 32'(out_rd), 32'd1);
    pop_expect("srai_pop", 32'h8);

    push(W_ILL, 32'hC);
    #1;
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_type", 32'(out_type), 32'd0);
    check("ill_rd", 32'(out_rd), 32'd0);
    check("ill_imm", out_imm, 32'd0);
    pop_expect("ill_pop", 32'hC);

    // fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) push(W_ADD2, 32'h100 + 32'(4 * i));
    #1;
    check("full_count", 32'(count_out), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_inst = W_ADD2; in_pc = 32'h110; out_ready = 1'b1;
    #1;
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    check("full_head_pc", out_pc, 32'h100);
    step();
    check("full_pop_only_count", 32'(count_out), 32'd3);
    check("ready_restored", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("refill_count", 32'(count_out), 32'd4);
    pop_expect("order1", 32'h104);
    pop_expect("order2", 32'h108);
    pop_expect("order3", 32'h10C);
    pop_expect("order4", 32'h110);
    check("drained_count", 32'(count_out), 32'd0);

    // simultaneous push and pop at count 2
    push(W_ADD2, 32'h200);
    push(W_ADD2, 32'h204);
    in_valid = 1'b1; in_pc = 32'h208; out_ready = 1'b1;
    step();
    check("pushpop_count", 32'(count_out), 32'd2);
    check("pushpop_head", out_pc, 32'h204);

    // global pause with both handshakes requested
    rdy_in = 1'b0;
    in_pc  = 32'h2F0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("pause_in_ready", 32'(in_ready), 32'd0);
      check("pause_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0; rdy_in = 1'b1;
    #1;
    check("pause_count", 32'(count_out), 32'd2);
    check("pause_head", out_pc, 32'h204);

    // flush with three entries and a same-cycle push
    push(W_ADD2, 32'h20C);
    check("preflush_count", 32'(count_out), 32'd3);
    flush_in = 1'b1; in_valid = 1'b1; in_pc = 32'h210;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush_in = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count_out), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    push(W_ADDI, 32'h300);
    check("postflush_head", out_pc, 32'h300);

    // asynchronous reset in the middle of a cycle
    push(W_ADDI, 32'h304);
    push(W_ADDI, 32'h308);
    check("prereset_count", 32'(count_out), 32'd3);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_count", 32'(count_out), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst_in = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
